// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, one-entry skid buffer and IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirect targets as a flagged NOP (adds if_misaligned).
module fetch_pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic             if_misaligned
`endif
);

  localparam logic [WIDTH-1:0] L_STEP       = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] L_ALIGN_MASK = ~(WIDTH'(3));

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
`ifdef FETCH_ALIGN_CHECK_EN
    , S_ERR
`endif
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_pc;
  logic             r_req;
  logic             r_if_valid;
  logic [WIDTH-1:0] r_if_instr;
  logic [WIDTH-1:0] r_if_pc;
  logic [WIDTH-1:0] r_if_pc_plus4;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_instr;
  logic [WIDTH-1:0] r_skid_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic             r_if_misaligned;
  logic             r_err_pending;
  logic             r_pend_mis;
  logic             w_tgt_mis;
  logic [WIDTH-1:0] w_rpc_next;
`endif

  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_skid_pc_next;
  logic [WIDTH-1:0] w_tgt_aligned;
  logic             w_outstanding;

  assign w_pc_next      = r_pc + L_STEP;
  assign w_skid_pc_next = r_skid_pc + L_STEP;
  assign w_tgt_aligned  = redirect_pc & L_ALIGN_MASK;
  // A request that is not completing this cycle must stay on the bus until acked.
  assign w_outstanding  = ((r_state == S_REQ) || (r_state == S_DROP)) && !imem_ack;
`ifdef FETCH_ALIGN_CHECK_EN
  assign w_tgt_mis      = |redirect_pc[1:0];
  assign w_rpc_next     = redirect_pc + L_STEP;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_pend_pc     <= RESET_PC;
      r_req         <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_pc     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_if_misaligned <= 1'b0;
      r_err_pending   <= 1'b0;
      r_pend_mis      <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_if_valid   <= 1'b0;
      r_skid_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_if_misaligned <= 1'b0;
      r_err_pending   <= 1'b0;
      r_pend_mis      <= w_tgt_mis;
`endif
      if (w_outstanding) begin
        // Keep the old address on the bus; the target is taken once the stale response drains.
        r_state <= S_DROP;
        r_req   <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        r_pend_pc <= w_tgt_mis ? redirect_pc : w_tgt_aligned;
`else
        r_pend_pc <= w_tgt_aligned;
`endif
      end
`ifdef FETCH_ALIGN_CHECK_EN
      else if (w_tgt_mis) begin
        r_state <= S_ERR;
        r_req   <= 1'b0;
        r_pc    <= redirect_pc;
        if (!stall) begin
          r_if_valid      <= 1'b1;
          r_if_instr      <= '0;
          r_if_pc         <= redirect_pc;
          r_if_pc_plus4   <= w_rpc_next;
          r_if_misaligned <= 1'b1;
        end else begin
          r_err_pending <= 1'b1;
        end
      end
`endif
      else begin
        r_state <= S_REQ;
        r_req   <= 1'b1;
        r_pc    <= w_tgt_aligned;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            r_pc <= w_pc_next;
            if (stall) begin
              r_skid_valid <= 1'b1;
              r_skid_instr <= imem_rdata;
              r_skid_pc    <= r_pc;
              r_state      <= S_HOLD;
              r_req        <= 1'b0;
            end else begin
              r_if_valid    <= 1'b1;
              r_if_instr    <= imem_rdata;
              r_if_pc       <= r_pc;
              r_if_pc_plus4 <= w_pc_next;
            end
          end else if (!stall) begin
            r_if_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_if_valid    <= r_skid_valid;
            r_if_instr    <= r_skid_instr;
            r_if_pc       <= r_skid_pc;
            r_if_pc_plus4 <= w_skid_pc_next;
            r_skid_valid  <= 1'b0;
            r_state       <= S_REQ;
            r_req         <= 1'b1;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            r_pc <= r_pend_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            if (r_pend_mis) begin
              r_state       <= S_ERR;
              r_req         <= 1'b0;
              r_err_pending <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
`else
            r_state <= S_REQ;
            r_req   <= 1'b1;
`endif
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        S_ERR: begin
          if (r_err_pending && !stall) begin
            r_if_valid      <= 1'b1;
            r_if_instr      <= '0;
            r_if_pc         <= r_pc;
            r_if_pc_plus4   <= w_pc_next;
            r_if_misaligned <= 1'b1;
            r_err_pending   <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  assign if_misaligned = r_if_misaligned;
`endif

endmodule
